uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_pkg.sv | 46 ++++
 rtl/even_parity_gen.sv | 15 +
 rtl/uart_tx_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmitter.
//
// Contents:
//   uart_state_e          : 3-bit transmitter FSM state encoding
//   CLKS_PER_BIT_DEFAULT  : default clk cycles per serial bit
//   BAUD_W / BIT_W        : baud counter and bit counter widths
//   FRAME_BITS_*          : frame length in bits with and without parity
//   frame_cycles()        : frame length in clk cycles for a configuration
//   even_parity()         : even-parity helper used by even_parity_gen
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int unsigned CLKS_PER_BIT_DEFAULT = 32'd16;

  // 16 bits covers the largest legal CLKS_PER_BIT (65535).
  localparam int unsigned BAUD_W = 32'd16;
  localparam int unsigned BIT_W  = 32'd3;

  // start + 8 data + parity + stop, and start + 8 data + stop.
  localparam int unsigned FRAME_BITS_PARITY    = 32'd11;
  localparam int unsigned FRAME_BITS_NO_PARITY = 32'd10;

  function automatic int unsigned frame_cycles(input int unsigned clks_per_bit,
                                               input logic        parity_en);
    int unsigned bits;
    if (parity_en) begin
      bits = FRAME_BITS_PARITY;
    end else begin
      bits = FRAME_BITS_NO_PARITY;
    end
    return bits * clks_per_bit;
  endfunction

  // Even parity: the bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/even_parity_gen.sv
// even_parity_gen -- combinational even-parity generator for one byte.
//
// Ports:
//   data_i   [7:0] : byte to protect
//   parity_o       : XOR of all eight bits of data_i
module even_parity_gen
  import uart_pkg::*;
(
  input  logic [7:0] data_i,
  output logic       parity_o
);

  assign parity_o = even_parity(data_i);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- 8-bit UART transmitter, LSB first, one stop bit.
//
// Frame: start(0), 8 data bits, optional even-parity bit, stop(1); every
// bit is held for CLKS_PER_BIT clk cycles.
//
// Build option:
//   UART_TX_PARITY_EN  defined   -> 11-bit frame including the parity bit
//                      undefined -> 10-bit frame, no parity state or logic
//
// Parameter:
//   CLKS_PER_BIT : clk cycles per serial bit, 2..65535
// Ports:
//   clk       : system clock, all state changes on its rising edge
//   rst       : asynchronous active-high reset
//   tx_start  : transmit request, only sampled while idle
//   tx_data   : byte to send, captured on the accepting edge
//   tx_serial : registered serial line, idle high
//   tx_busy   : high in every non-idle state
//   tx_done   : one-cycle pulse in the last cycle of the stop bit
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_serial,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 32'd1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q,  baud_d;
  logic [BIT_W-1:0]  bit_q,   bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_serial_q, tx_serial_d;
  logic              tx_busy_q,   tx_busy_d;
  logic              tx_done_q,   tx_done_d;
  logic              baud_last_s;

`ifdef UART_TX_PARITY_EN
  // Unshifted copy of the accepted byte; the parity bit is taken from this
  // copy so later changes on tx_data cannot leak into the frame.
  logic [7:0] data_q, data_d;
  logic       parity_s;

  even_parity_gen u_parity (
    .data_i   (data_q),
    .parity_o (parity_s)
  );
`endif

  assign baud_last_s = (baud_q == BAUD_LAST);

  // Next-state logic: bit timing, bit counting and data shifting.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    data_d  = data_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d = ST_START;
          baud_d  = {BAUD_W{1'b0}};
          bit_d   = {BIT_W{1'b0}};
          shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
          data_d  = tx_data;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (baud_last_s) begin
          state_d = ST_DATA;
          baud_d  = {BAUD_W{1'b0}};
        end else begin
          baud_d  = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
      ST_DATA: begin
        if (baud_last_s) begin
          baud_d  = {BAUD_W{1'b0}};
          // Line always shows shift_q[0]; move the next bit into place.
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d = 3'd0;
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d  = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (baud_last_s) begin
          state_d = ST_STOP;
          baud_d  = {BAUD_W{1'b0}};
        end else begin
          baud_d  = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
`endif
      ST_STOP: begin
        if (baud_last_s) begin
          state_d = ST_IDLE;
          baud_d  = {BAUD_W{1'b0}};
        end else begin
          baud_d  = baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = {BAUD_W{1'b0}};
        bit_d   = {BIT_W{1'b0}};
        shift_d = 8'h00;
      end
    endcase
  end

  // Output next values, derived from the next state so the registered
  // outputs line up with the state they describe (no extra cycle of lag).
  always_comb begin
    tx_serial_d = 1'b1;
    tx_busy_d   = (state_d != ST_IDLE);
    tx_done_d   = (state_d == ST_STOP) && (baud_d == BAUD_LAST);
    case (state_d)
      ST_IDLE:   tx_serial_d = 1'b1;
      ST_START:  tx_serial_d = 1'b0;
      ST_DATA:   tx_serial_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_serial_d = parity_s;
`endif
      ST_STOP:   tx_serial_d = 1'b1;
      default:   tx_serial_d = 1'b1;
    endcase
  end

  // State, counters, data and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      baud_q      <= {BAUD_W{1'b0}};
      bit_q       <= {BIT_W{1'b0}};
      shift_q     <= 8'h00;
`ifdef UART_TX_PARITY_EN
      data_q      <= 8'h00;
`endif
      tx_serial_q <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
`ifdef UART_TX_PARITY_EN
      data_q      <= data_d;
`endif
      tx_serial_q <= tx_serial_d;
      tx_busy_q   <= tx_busy_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx_serial = tx_serial_q;
  assign tx_busy   = tx_busy_q;
  assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl -- directed self-checking bench for uart_tx_ctrl with
// CLKS_PER_BIT = 4. Works with UART_TX_PARITY_EN defined or undefined.
module tb_uart_tx_ctrl;

  localparam int CPB = 4;

  // Frame length in cycles and hand-computed frame bit patterns
  // (bit 0 = start bit, sent first).
`ifdef UART_TX_PARITY_EN
  localparam int         FCYC = 44;
  localparam logic [10:0] F55 = 11'h4AA;
  localparam logic [10:0] F07 = 11'h60E;
  localparam logic [10:0] F00 = 11'h400;
  localparam logic [10:0] FFF = 11'h5FE;
  localparam logic [10:0] F3C = 11'h478;
  localparam logic [10:0] F01 = 11'h602;
  localparam logic [10:0] F52 = 11'h6A4;
  localparam logic [10:0] FA3 = 11'h546;
`else
  localparam int         FCYC = 40;
  localparam logic [10:0] F55 = 11'h2AA;
  localparam logic [10:0] F07 = 11'h20E;
  localparam logic [10:0] F00 = 11'h200;
  localparam logic [10:0] FFF = 11'h3FE;
  localparam logic [10:0] F3C = 11'h278;
  localparam logic [10:0] F01 = 11'h202;
  localparam logic [10:0] F52 = 11'h2A4;
  localparam logic [10:0] FA3 = 11'h346;
`endif

  logic       clk;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_serial;
  logic       tx_busy;
  logic       tx_done;

  int vectors     = 0;
  int miscompares = 0;

  uart_tx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_done   (tx_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_serial"}, tx_serial, 1'b1);
    chk({tag, "_busy"},   tx_busy,   1'b0);
    chk({tag, "_done"},   tx_done,   1'b0);
  endtask

  // Request a frame from IDLE; returns in cycle 1 after acceptance.
  task automatic start_frame(input logic [7:0] d, input bit hold);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    if (!hold) tx_start = 1'b0;
  endtask

  // Check cycles 1..n_cyc of a frame. poke_a/poke_b pulse tx_start and
  // scramble tx_data in those cycles; hold keeps tx_start high and loads
  // next_d onto tx_data mid-frame.
  task automatic check_cycles(input logic [10:0] exp, input int n_cyc,
                              input int poke_a, input int poke_b,
                              input bit hold, input logic [7:0] next_d);
    int k;
    for (int c = 1; c <= n_cyc; c++) begin
      k = (c - 1) / CPB;
      chk($sformatf("serial_c%0d", c), tx_serial, exp[k]);
      chk($sformatf("busy_c%0d", c),   tx_busy,   1'b1);
      chk($sformatf("done_c%0d", c),   tx_done,   (c == FCYC));
      if (hold) begin
        tx_start = 1'b1;
        if (c == CPB * 3) tx_data = next_d;
      end else begin
        tx_start = (c == poke_a) || (c == poke_b);
        if ((c == poke_a) || (c == poke_b)) tx_data = ~tx_data;
      end
      tick();
    end
  endtask

  task automatic plain_frame(input logic [7:0] d, input logic [10:0] exp, input string tag);
    start_frame(d, 1'b0);
    check_cycles(exp, FCYC, 0, 0, 1'b0, 8'h00);
    tx_start = 1'b0;
    idle_chk(tag);
  endtask

  initial begin
    rst      = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;

    // Asynchronous reset, checked before any clock edge.
    #2 rst = 1'b1;
    #1;
    idle_chk("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();
    idle_chk("post_reset");

    // 0x55 with tx_start pulses mid-DATA and in the tx_done cycle.
    start_frame(8'h55, 1'b0);
    check_cycles(F55, FCYC, 15, FCYC, 1'b0, 8'h00);
    tx_start = 1'b0;
    idle_chk("f55_end");
    tick();
    idle_chk("f55_not_queued");

    // Parity corner bytes.
    plain_frame(8'h07, F07, "f07");
    plain_frame(8'h00, F00, "f00");
    plain_frame(8'hFF, FFF, "fff");

    // Back-to-back with tx_start held high; tx_data changes mid-frame.
    start_frame(8'h3C, 1'b1);
    check_cycles(F3C, FCYC, 0, 0, 1'b1, 8'h01);
    idle_chk("b2b_gap");
    tick();
    check_cycles(F01, FCYC, 0, 0, 1'b1, 8'hEE);
    tx_start = 1'b0;
    idle_chk("b2b_end");

    // Reset in cycle 20 of a frame: immediate idle line, no tx_done.
    start_frame(8'h52, 1'b0);
    check_cycles(F52, 19, 0, 0, 1'b0, 8'h00);
    chk("pre_rst_serial", tx_serial, 1'b0);
    rst = 1'b1;
    #1;
    idle_chk("mid_rst");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      idle_chk($sformatf("abort_%0d", i));
      tick();
    end
    plain_frame(8'hA3, FA3, "fa3");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
